led_status_ctrl: RTL and testbench
==================================

# led_status_ctrl

Display controller for the 16 board LEDs in the I2S serializer/deserializer design. Shares the LED bank between the deserializer's left and right sample streams and a peak-magnitude meter, and rate-limits updates so the values stay readable. A debounced push button steps through display modes. Sits between the I2S deserializer outputs and the LED pins, and replaces direct button-edge latching of sample data.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 2.
- UPDATE_DIV, 5000000: clk cycles per display refresh tick (10 Hz at 50 MHz); minimum 2.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- btn_n  in  1  raw push button, active-low, asynchronous to clk.
- l_data  in  16  left-channel sample, two's complement.
- l_valid  in  1  single-cycle strobe; l_data is valid.
- r_data  in  16  right-channel sample, two's complement.
- r_valid  in  1  single-cycle strobe; r_data is valid.
- led  out  16  LED drive; led[0] is LEDR0.
- mode  out  2  current display mode.
- btn_pulse  out  1  one-cycle strobe per accepted press.

## Operation
- Reset values: led=0, mode=LEFT (0), btn_pulse=0. Internally: sync flops=1, stable level=1 (released), debounce counter=0, last_l=0, last_r=0, peak=0, refresh counter=0, load_pending=0.
- Button path: 2-flop synchronizer, then debounce.
  - The debounce counter increments while the synced level differs from the stable level. It clears on any cycle where they match.
  - At DEBOUNCE_CYCLES consecutive differing cycles, the stable level takes the synced value and the counter clears.
  - A stable 1→0 transition produces btn_pulse. A release produces no pulse.
- Mode state machine, advanced on btn_pulse: LEFT(0) → RIGHT(1) → PEAK(2) → FREEZE(3) → LEFT.
- Capture:
  - l_valid loads last_l. r_valid loads last_r.
  - Both strobes in the same cycle: both registers load.
- Peak accumulator:
  - Each valid sample contributes |sample|. -32768 saturates to 32767, so peak stays ≤ 0x7FFF.
  - peak = max(peak, contributions of this cycle).
- Refresh tick: the refresh counter counts 0..UPDATE_DIV-1 and wraps. tick is asserted when the count equals UPDATE_DIV-1.
- On tick:
  - LEFT: led ← last_l.
  - RIGHT: led ← last_r.
  - PEAK: led ← peak view.
  - FREEZE: led holds.
  - The peak accumulator restarts in every mode, including FREEZE. It restarts from this cycle's contributions, or 0 if there are none.
- Sample strobe in the same cycle as tick: led takes the pre-update register value. The new sample lands in the capture register and seeds the restarted peak.
- Mode change:
  - On btn_pulse, mode advances. If the new mode is not FREEZE, load_pending is set.
  - On the following cycle: led loads from the new mode's source, the refresh counter clears, and load_pending clears.
  - Entering FREEZE: led keeps its value.
- btn_pulse coinciding with tick: the tick uses the old mode. The pending load follows next cycle.
- Reset asserted mid-operation returns all state to reset values immediately, with no glitch on led beyond going to 0.

## Timing
- btn_n held low from clk edge k: btn_pulse is high in cycle k+2+DEBOUNCE_CYCLES. mode changes in the next cycle.
- led changes on the edge after the tick cycle, or on the edge after load_pending. Sample to LED latency is at most UPDATE_DIV+1 cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- No handshake back-pressure: strobes are never stalled or dropped.

## Configuration
- LED_BARGRAPH_EN defined:
  - PEAK mode shows a thermometer. For peak=0, led=0. Otherwise led[n:0] are all 1 and the upper bits are 0, where n is the index of peak's MSB (n ≤ 14).
  - Example: peak=0x0100 → led=0x01FF.
- LED_BARGRAPH_EN undefined: PEAK mode shows the raw peak value.

## Structure
- Package led_status_pkg holds:
  - the mode encoding (LEFT/RIGHT/PEAK/FREEZE enum or localparams);
  - the sample width constant (16) and the PEAK_MAX constant 16'h7FFF.
- Sub-module btn_debounce contains the synchronizer and debounce counter. Parameter DEBOUNCE_CYCLES; ports clk, rst, btn_n, press.
- Mode FSM, capture, peak, refresh counter and LED mux stay in led_status_ctrl.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and UPDATE_DIV=8.
- Reset, then l_valid with l_data=0x1234 → led=0x1234 after the next tick; mode=0.
- Press btn_n low for 10 cycles → single btn_pulse at k+6, mode=1, led=last_r one cycle later.
- btn_n low for 3 cycles only → no btn_pulse, mode unchanged.
- In PEAK, l_data=0x8000 and r_data=0x0010 in the same cycle → led=0x7FFF at tick, or 0x7FFF as thermometer with LED_BARGRAPH_EN; next tick with no samples → led=0.
- In FREEZE, samples 0xAAAA and ticks → led unchanged; one press → mode=LEFT, led=0xAAAA one cycle after the pulse.
- Assert rst mid-count during a press with led=0x5555 → led=0, mode=0, no btn_pulse after release of rst while btn_n stays high.

Source files
------------

// File: rtl/led_status_pkg.sv
// +----------------------------------------------------------------------------+
// | led_status_pkg : mode encoding, sample constants and magnitude helpers      |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package led_status_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_PEAK   = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] PEAK_MAX = 16'h7FFF;

  // |s| for a two's complement sample; the most negative code clips to PEAK_MAX.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] m;
    if (!s[SAMPLE_W-1]) begin
      m = s;
    end else if (s == 16'h8000) begin
      m = PEAK_MAX;
    end else begin
      m = -s;
    end
    return m;
  endfunction

  function automatic logic [SAMPLE_W-1:0] thermometer(input logic [SAMPLE_W-1:0] p);
    logic [SAMPLE_W-1:0] t;
    for (int i = 0; i < SAMPLE_W; i++) begin
      t[i] = |(p >> i);
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------------+
// | btn_debounce : 2-flop synchronizer plus level debounce, pulses on press     |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ;
  logic             accept;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    differ   = (sync2_q != stable_q);
    accept   = differ && (cnt_q == CNT_LAST);
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (accept) begin
      stable_d = sync2_q;
      // Active-low button: only the released-to-pressed edge pulses.
      press_d  = ~sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/led_status_ctrl.sv
// +----------------------------------------------------------------------------+
// | led_status_ctrl : LED bank mux for L/R samples and peak meter, rate-limited  |
// | Optional LED_BARGRAPH_EN shows the peak as a thermometer. Revision 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int UPDATE_DIV      = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_n,
  input  logic [15:0] l_data,
  input  logic        l_valid,
  input  logic [15:0] r_data,
  input  logic        r_valid,
  output logic [15:0] led,
  output logic [1:0]  mode,
  output logic        btn_pulse
);

  localparam int REF_W = $clog2(UPDATE_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(UPDATE_DIV - 1);

  mode_t                mode_q, mode_d;
  logic [SAMPLE_W-1:0]  led_q, led_d;
  logic [SAMPLE_W-1:0]  last_l_q, last_l_d;
  logic [SAMPLE_W-1:0]  last_r_q, last_r_d;
  logic [SAMPLE_W-1:0]  peak_q, peak_d;
  logic [REF_W-1:0]     ref_cnt_q, ref_cnt_d;
  logic                 load_pending_q, load_pending_d;
  logic [SAMPLE_W-1:0]  l_mag, r_mag, contrib, peak_view, src;
  logic                 tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_n),
    .press(btn_pulse)
  );

  always_comb begin
`ifdef LED_BARGRAPH_EN
    peak_view = thermometer(peak_q);
`else
    peak_view = peak_q;
`endif
  end

  always_comb begin
    l_mag   = l_valid ? abs_sat(l_data) : '0;
    r_mag   = r_valid ? abs_sat(r_data) : '0;
    contrib = (l_mag > r_mag) ? l_mag : r_mag;
    tick    = (ref_cnt_q == REF_LAST);

    last_l_d = l_valid ? l_data : last_l_q;
    last_r_d = r_valid ? r_data : last_r_q;

    // The tick window restarts from this cycle's samples so none are lost.
    if (tick) begin
      peak_d = contrib;
    end else begin
      peak_d = (contrib > peak_q) ? contrib : peak_q;
    end

    if (load_pending_q || tick) begin
      ref_cnt_d = '0;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end

    case (mode_q)
      MODE_LEFT:  src = last_l_q;
      MODE_RIGHT: src = last_r_q;
      MODE_PEAK:  src = peak_view;
      default:    src = led_q;
    endcase
    led_d = (tick || load_pending_q) ? src : led_q;

    mode_d         = mode_q;
    load_pending_d = 1'b0;
    if (btn_pulse) begin
      case (mode_q)
        MODE_LEFT:  mode_d = MODE_RIGHT;
        MODE_RIGHT: mode_d = MODE_PEAK;
        MODE_PEAK:  mode_d = MODE_FREEZE;
        default:    mode_d = MODE_LEFT;
      endcase
      load_pending_d = (mode_d != MODE_FREEZE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= MODE_LEFT;
      led_q          <= '0;
      last_l_q       <= '0;
      last_r_q       <= '0;
      peak_q         <= '0;
      ref_cnt_q      <= '0;
      load_pending_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      led_q          <= led_d;
      last_l_q       <= last_l_d;
      last_r_q       <= last_r_d;
      peak_q         <= peak_d;
      ref_cnt_q      <= ref_cnt_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_led_status_ctrl : directed, table-driven bench for led_status_ctrl        |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_led_status_ctrl;

  localparam int DEB = 4;
  localparam int UPD = 8;

  typedef struct {
    logic        lv;
    logic [15:0] ld;
    logic        rv;
    logic [15:0] rd;
    logic [15:0] exp_raw;
    logic [15:0] exp_bar;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_n = 1'b1;
  logic [15:0] l_data = '0;
  logic        l_valid = 1'b0;
  logic [15:0] r_data = '0;
  logic        r_valid = 1'b0;
  logic [15:0] led;
  logic [1:0]  mode;
  logic        btn_pulse;

  int n_chk = 0;
  int n_fail = 0;

  vec_t tbl [7];

  led_status_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .UPDATE_DIV     (UPD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .l_data   (l_data),
    .l_valid  (l_valid),
    .r_data   (r_data),
    .r_valid  (r_valid),
    .led      (led),
    .mode     (mode),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic lv, input logic [15:0] ld, input logic rv, input logic [15:0] rd);
    l_valid = lv; l_data = ld; r_valid = rv; r_data = rd;
    step();
    l_valid = 1'b0; r_valid = 1'b0;
  endtask

  // Holds the button down until the pulse is seen (bounded), then releases it.
  task automatic press_to_pulse();
    logic ok;
    int   n;
    ok = 1'b0;
    n = 0;
    btn_n = 1'b0;
    while (!ok && n < 20) begin
      step();
      n++;
      if (btn_pulse) ok = 1'b1;
    end
    check("press_pulse_seen", {31'd0, ok}, 32'd1);
    btn_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [15:0] e;

    tbl[0] = '{1'b1, 16'h8000, 1'b1, 16'h0010, 16'h7FFF, 16'h7FFF};
    tbl[1] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0100, 16'h01FF};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 16'h0001};
    tbl[3] = '{1'b1, 16'h0005, 1'b1, 16'hFF00, 16'h0100, 16'h01FF};
    tbl[4] = '{1'b1, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF, 16'h7FFF};
    tbl[5] = '{1'b1, 16'hC000, 1'b0, 16'h0000, 16'h4000, 16'h7FFF};
    tbl[6] = '{1'b0, 16'h7000, 1'b0, 16'h8000, 16'h0000, 16'h0000};

    // Reset state
    steps(2);
    check("reset_led", {16'd0, led}, 32'h0);
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_pulse", {31'd0, btn_pulse}, 32'd0);
    rst = 1'b0;
    step();

    // LEFT shows captured left sample at the next tick; right also captured
    sample(1'b1, 16'h1234, 1'b1, 16'h00C3);
    steps(UPD);
    check("left_led", {16'd0, led}, 32'h1234);
    check("left_mode", {30'd0, mode}, 32'd0);

    // Press held 10 cycles: exactly one pulse at k+2+DEB, mode then led follow
    btn_n = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == DEB + 2) check("press_pulse_at", {31'd0, btn_pulse}, 32'd1);
      else if (btn_pulse) pulses++;
      if (k == DEB + 3) check("press_mode", {30'd0, mode}, 32'd1);
      if (k == DEB + 4) check("press_led_right", {16'd0, led}, 32'h00C3);
    end
    btn_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (btn_pulse) pulses++;
    end
    check("press_extra_pulses", pulses, 0);

    // Short glitch
    btn_n = 1'b0;
    steps(3);
    btn_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_pulse) pulses++;
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_mode", {30'd0, mode}, 32'd1);

    // PEAK mode table
    press_to_pulse();
    steps(10);
    check("peak_mode", {30'd0, mode}, 32'd2);
    for (int i = 0; i < 7; i++) begin
`ifdef LED_BARGRAPH_EN
      e = tbl[i].exp_bar;
`else
      e = tbl[i].exp_raw;
`endif
      sample(tbl[i].lv, tbl[i].ld, tbl[i].rv, tbl[i].rd);
      steps(UPD);
      check($sformatf("peak_vec%0d", i), {16'd0, led}, {16'd0, e});
      steps(UPD);
      check($sformatf("peak_vec%0d_idle", i), {16'd0, led}, 32'h0);
    end

    // FREEZE holds through samples and ticks
    press_to_pulse();
    steps(10);
    check("freeze_mode", {30'd0, mode}, 32'd3);
    sample(1'b1, 16'hAAAA, 1'b1, 16'hAAAA);
    steps(2 * UPD + 2);
    check("freeze_hold", {16'd0, led}, 32'h0);
    press_to_pulse();
    step();
    check("unfreeze_mode", {30'd0, mode}, 32'd0);
    step();
    check("unfreeze_led", {16'd0, led}, 32'hAAAA);
    steps(10);

    // Reset mid-press
    sample(1'b1, 16'h5555, 1'b0, 16'h0000);
    steps(UPD);
    check("pre_reset_led", {16'd0, led}, 32'h5555);
    btn_n = 1'b0;
    steps(3);
    rst = 1'b1;
    btn_n = 1'b1;
    #1;
    check("async_reset_led", {16'd0, led}, 32'h0);
    check("async_reset_mode", {30'd0, mode}, 32'd0);
    steps(2);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_pulse) pulses++;
    end
    check("post_reset_pulses", pulses, 0);
    check("post_reset_led", {16'd0, led}, 32'h0);
    check("post_reset_mode", {30'd0, mode}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
